// File: rtl/jtag_pkg.sv
// Shared types and constants for the jtag shift engine
// and the scan sequencer that feeds it.
package jtag_pkg;

    localparam int   DR_WORDS = 4;
    localparam logic OP_IR    = 1'b0;
    localparam logic OP_DR    = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IR,
        S_LOAD_DR,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DONE
    } seq_state_type;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } state_type;

endpackage

// File: rtl/jtag_watchdog.sv
// Transaction watchdog: counts enabled cycles and pulses
// expire on the TIMEOUT_CYCLES-th one.
module jtag_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expire = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// Scan command sequencer: loads the engine FIFOs for one
// IR/DR command and then issues the engine transactions.
module jtag_scan_sequencer #(
    parameter int DATA_INSTRUCTION = 10,
    parameter int DATA_FIFO        = 8,
    parameter int DR_WORDS         = jtag_pkg::DR_WORDS,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_has_ir,
    input  logic                          cmd_has_dr,
    input  logic [DATA_INSTRUCTION-1:0]   cmd_ir,
    input  logic [DATA_FIFO*DR_WORDS-1:0] cmd_dr,
    output logic                          done,
    output logic                          err,
    output logic                          op,
    output logic                          work,
    input  logic                          busy,
    output logic                          wr_instruction,
    output logic [DATA_INSTRUCTION-1:0]   wdata_instruction,
    input  logic                          full_instruction,
    output logic                          wr_data,
    output logic [DATA_FIFO-1:0]          wdata_data,
    input  logic                          full_data
);

    import jtag_pkg::*;

    localparam int             WCW       = $clog2(DR_WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(DR_WORDS - 1);

    seq_state_type                 state;
    logic                          ir_pend;
    logic                          dr_pend;
    logic [DATA_INSTRUCTION-1:0]   ir_q;
    logic [DATA_FIFO*DR_WORDS-1:0] dr_q;
    logic [WCW-1:0]                word;
    logic                          accept;
    logic                          waiting;
    logic                          issuing;
    logic                          expire;

    assign accept  = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign waiting = (state == S_WAIT_ACK) || (state == S_WAIT_DONE);
    assign issuing = (state == S_ISSUE);

    // Strobes are gated by the live full/busy inputs so they can never
    // fire into a full FIFO or a busy engine.
    assign wr_instruction    = (state == S_LOAD_IR) && !full_instruction;
    assign wdata_instruction = ir_q;
    assign wr_data           = (state == S_LOAD_DR) && !full_data;
    assign wdata_data        = dr_q[DATA_FIFO-1:0];
    assign work              = issuing && !busy;
    assign done              = (state == S_DONE) || expire;
    assign err               = expire;

    jtag_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (issuing),
        .enable(waiting),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            op        <= OP_IR;
            ir_pend   <= 1'b0;
            dr_pend   <= 1'b0;
            ir_q      <= '0;
            dr_q      <= '0;
            word      <= '0;
        end else begin
            cmd_ready <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        ir_q    <= cmd_ir;
                        dr_q    <= cmd_dr;
                        ir_pend <= cmd_has_ir;
                        dr_pend <= cmd_has_dr;
                        if (cmd_has_ir) state <= S_LOAD_IR;
                        else if (cmd_has_dr) state <= S_LOAD_DR;
                        else state <= S_DONE;
                    end else begin
                        cmd_ready <= !busy;
                    end
                end
                S_LOAD_IR: begin
                    if (!full_instruction) begin
                        if (dr_pend) begin
                            state <= S_LOAD_DR;
                        end else begin
                            op    <= OP_IR;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_LOAD_DR: begin
                    if (!full_data) begin
                        dr_q <= dr_q >> DATA_FIFO;
                        word <= word + 1'b1;
                        if (word == LAST_WORD) begin
                            word  <= '0;
                            op    <= ir_pend ? OP_IR : OP_DR;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!busy) state <= S_WAIT_ACK;
                end
                S_WAIT_ACK, S_WAIT_DONE: begin
                    if (expire) begin
                        ir_pend <= 1'b0;
                        dr_pend <= 1'b0;
                        state   <= S_IDLE;
                    end else if (state == S_WAIT_ACK) begin
                        if (busy) state <= S_WAIT_DONE;
                    end else if (!busy) begin
                        // The finished transaction is IR while IR is still pending.
                        if (ir_pend) begin
                            ir_pend <= 1'b0;
                            if (dr_pend) begin
                                op    <= OP_DR;
                                state <= S_ISSUE;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            dr_pend <= 1'b0;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
